operand_fetch: RTL and testbench
================================

OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 Parameter W, default 16, datapath width.
REQ-002 Parameter NREG, default 8, register count (address width = 3).
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 in_valid  in  1  upstream instruction valid.
REQ-006 in_ready  out  1  stage accepts instruction this cycle.
REQ-007 in_op  in  3  [1:0] ALU op (00 add, 01 sub, 10 and, 11 or); [2] B-from-immediate.
REQ-008 in_rs, in_rt, in_rd  in  3 each  source A, source B, destination register.
REQ-009 in_imm  in  8  signed immediate.
REQ-010 wb_en, wb_addr, wb_data  in  1/3/W  writeback port from the downstream result stage.
REQ-011 out_valid  out  1  operands valid toward the ALU.
REQ-012 out_ready  in  1  downstream consumes operands.
REQ-013 alu_ctrl  out  2  ALU control code.
REQ-014 alu_a, alu_b  out  W each  ALU operands.
REQ-015 out_rd  out  3  destination tag travelling with operands.

Function
REQ-016 Register file of NREG x W; r0 reads 0 always, writes to r0 ignored.
REQ-017 Write on clk when wb_en, wb_addr != 0.
REQ-018 Scoreboard: one pending bit per register; r0 never pending.
REQ-019 Hazard = pending[rs] | (pending[rt] & !in_op[2]) | pending[rd], each term masked when wb_en and wb_addr equals that register this cycle.
REQ-020 in_ready = (!out_valid | out_ready) & !hazard; combinational from inputs and state.
REQ-021 Accept = in_valid & in_ready; accepted instruction appears on outputs next cycle (latency 1), out_valid=1.
REQ-022 Operand A = rs value; B = rt value, or sign-extended in_imm to W when in_op[2]=1.
REQ-023 Bypass: if wb_en and wb_addr == rs (or rt), same-cycle wb_data used instead of stored value (r0 excluded).
REQ-024 alu_ctrl = in_op[1:0] registered with operands; out_rd registered likewise.
REQ-025 Outputs held stable while out_valid & !out_ready; no new accept in that case.
REQ-026 out_valid clears after out_ready handshake with no accept in same cycle; accept and drain same cycle keeps out_valid=1 with new data.
REQ-027 On accept with rd != 0, set pending[rd]; on wb_en clear pending[wb_addr]; same-register set and clear in one cycle: set wins.
REQ-028 in_valid=0: outputs and scoreboard unchanged except writeback effects.

Reset
REQ-029 Reset asserted: out_valid=0, alu_ctrl=0, alu_a=0, alu_b=0, out_rd=0, all pending=0, all registers=0, immediately (asynchronous).
REQ-030 Reset mid-handshake discards held operands; first post-reset edge observes empty stage, in_ready=1 (absent hazard).
REQ-031 Writeback or input activity during reset ignored.

Structure
REQ-032 Shared package alu_pkg: W, NREG, op enum (ALU_ADD=00, ALU_SUB=01, ALU_AND=10, ALU_OR=11), register-address typedef.
REQ-033 One sub-module regfile: two async read ports, one sync write port, r0 hardwired zero; scoreboard and output register in operand_fetch.

Verification
REQ-034 Reset, write r1=0x0005, r2=0x0003 via wb; issue op=01 rs=1 rt=2 rd=3 -> next cycle out_valid=1, alu_ctrl=01, alu_a=0x0005, alu_b=0x0003, out_rd=3, pending[3]=1.
REQ-035 Issue op=100 rs=1 imm=0xFE rd=4 -> alu_b=0xFFFE, alu_a=r1.
REQ-036 With pending[3]=1 issue rs=3 -> in_ready=0; assert wb_en addr=3 data=0x1234 same cycle -> in_ready=1, alu_a=0x1234 next cycle.
REQ-037 Hold out_ready=0 3 cycles with in_valid=1 -> outputs stable, in_ready=0; release -> handshake then new operands next cycle.
REQ-038 Issue rd=0 -> no pending set; wb to r0 data=0xFFFF -> r0 still reads 0.
REQ-039 Assert reset while out_valid=1 and pending[5]=1 -> out_valid=0, pending cleared immediately, in_ready=1 after release.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared constants and types for the operand fetch stage and its register file.
package alu_pkg;

    localparam int W    = 16;
    localparam int NREG = 8;
    localparam int AW   = $clog2(NREG);

    // Register address as carried on every source/destination field.
    typedef logic [AW-1:0] reg_addr_t;

    // ALU operation codes carried in in_op[1:0] and presented on alu_ctrl.
    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

endpackage

// File: rtl/operand_fetch_if.sv
// Handshake and writeback bundle of the operand fetch stage.
// master = upstream issue / downstream ALU side, slave = the fetch stage.
interface operand_fetch_if
    import alu_pkg::*;
#(
    parameter int W = alu_pkg::W
);
    // Instruction side
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    reg_addr_t       in_rs;
    reg_addr_t       in_rt;
    reg_addr_t       in_rd;
    logic [7:0]      in_imm;

    // Writeback from the result stage
    logic            wb_en;
    reg_addr_t       wb_addr;
    logic [W-1:0]    wb_data;

    // Operands toward the ALU
    logic            out_valid;
    logic            out_ready;
    logic [1:0]      alu_ctrl;
    logic [W-1:0]    alu_a;
    logic [W-1:0]    alu_b;
    reg_addr_t       out_rd;

    modport master (
        output in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        output wb_en, wb_addr, wb_data,
        output out_ready,
        input  in_ready, out_valid, alu_ctrl, alu_a, alu_b, out_rd
    );

    modport slave (
        input  in_valid, in_op, in_rs, in_rt, in_rd, in_imm,
        input  wb_en, wb_addr, wb_data,
        input  out_ready,
        output in_ready, out_valid, alu_ctrl, alu_a, alu_b, out_rd
    );

endinterface

// File: rtl/operand_fetch_regfile.sv
// Register file: two asynchronous read ports, one synchronous write port,
// r0 hardwired to zero.
module regfile
    import alu_pkg::*;
#(
    parameter int W    = alu_pkg::W,
    parameter int NREG = alu_pkg::NREG
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         we,
    input  reg_addr_t    waddr,
    input  logic [W-1:0] wdata,
    input  reg_addr_t    raddr_a,
    output logic [W-1:0] rdata_a,
    input  reg_addr_t    raddr_b,
    output logic [W-1:0] rdata_b
);

    logic [NREG-1:0][W-1:0] mem_reg;

    // Storage write; r0 is never written so it stays at its reset value of zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_reg <= '0;
        end else if (we && (waddr != '0)) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : mem_reg[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : mem_reg[raddr_b];

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: reads sources (with writeback bypass), tracks pending
// destinations in a scoreboard, and registers operands toward the ALU.
module operand_fetch
    import alu_pkg::*;
#(
    parameter int W    = alu_pkg::W,
    parameter int NREG = alu_pkg::NREG
) (
    input  logic                clk,
    input  logic                reset,
    operand_fetch_if.slave      bus
);

    logic [NREG-1:0] pending_reg;
    logic [NREG-1:0] pending_next;
    logic [NREG-1:0] busy;

    logic            out_valid_reg;
    alu_op_t         alu_ctrl_reg;
    logic [W-1:0]    alu_a_reg;
    logic [W-1:0]    alu_b_reg;
    reg_addr_t       out_rd_reg;

    logic [W-1:0]    rf_a;
    logic [W-1:0]    rf_b;
    logic [W-1:0]    opnd_a;
    logic [W-1:0]    opnd_b;
    logic [W-1:0]    imm_ext;
    logic            bypass_a;
    logic            bypass_b;
    logic            hazard;
    logic            in_ready_int;
    logic            accept;

    regfile #(
        .W    (W),
        .NREG (NREG)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .we      (bus.wb_en),
        .waddr   (bus.wb_addr),
        .wdata   (bus.wb_data),
        .raddr_a (bus.in_rs),
        .rdata_a (rf_a),
        .raddr_b (bus.in_rt),
        .rdata_b (rf_b)
    );

    // A register is busy when pending and not being written back this cycle.
    // The scoreboard next state is built per register: a new claim beats a
    // same-cycle writeback release, and r0 is never claimed.
    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_sb
            assign busy[gi] = pending_reg[gi]
                            & ~(bus.wb_en & (bus.wb_addr == reg_addr_t'(gi)));
            if (gi == 0) begin : g_r0
                assign pending_next[gi] = 1'b0;
            end else begin : g_rn
                assign pending_next[gi] =
                    (accept && (bus.in_rd == reg_addr_t'(gi))) ? 1'b1 :
                    (bus.wb_en && (bus.wb_addr == reg_addr_t'(gi))) ? 1'b0 :
                    pending_reg[gi];
            end
        end
    endgenerate

    // B from the immediate ignores rt, so rt only stalls for register-register ops.
    assign hazard = busy[bus.in_rs]
                  | (busy[bus.in_rt] & ~bus.in_op[2])
                  | busy[bus.in_rd];

    assign in_ready_int = (~out_valid_reg | bus.out_ready) & ~hazard;
    assign accept       = bus.in_valid & in_ready_int;
    assign bus.in_ready = in_ready_int;

    // Same-cycle writeback data replaces the stored value; r0 always reads zero.
    assign bypass_a = bus.wb_en && (bus.wb_addr == bus.in_rs) && (bus.in_rs != '0);
    assign bypass_b = bus.wb_en && (bus.wb_addr == bus.in_rt) && (bus.in_rt != '0);
    assign imm_ext  = {{(W-8){bus.in_imm[7]}}, bus.in_imm};
    assign opnd_a   = bypass_a ? bus.wb_data : rf_a;
    assign opnd_b   = bus.in_op[2] ? imm_ext : (bypass_b ? bus.wb_data : rf_b);

    // Scoreboard state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= pending_next;
        end
    end

    // Output stage: load on accept, empty after a drain with no new accept,
    // otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_reg <= 1'b0;
            alu_ctrl_reg  <= ALU_ADD;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            out_rd_reg    <= '0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            alu_ctrl_reg  <= alu_op_t'(bus.in_op[1:0]);
            alu_a_reg     <= opnd_a;
            alu_b_reg     <= opnd_b;
            out_rd_reg    <= bus.in_rd;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.alu_ctrl  = alu_ctrl_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.out_rd    = out_rd_reg;

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: directed scenarios plus a randomized
// run against a behavioural model of registers, scoreboard and output stage.
module tb_operand_fetch;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    operand_fetch_if #(.W(16)) bus ();

    operand_fetch #(.W(16), .NREG(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model state
    logic [15:0] m_reg [8];
    bit          m_pend [8];
    logic        m_ov;
    logic [1:0]  m_ctrl;
    logic [15:0] m_a;
    logic [15:0] m_b;
    logic [2:0]  m_rd;
    logic        exp_ready;
    logic        obs_ready;

    wire [37:0] obs_out = {bus.out_valid, bus.alu_ctrl, bus.alu_a, bus.alu_b, bus.out_rd};
    wire [37:0] mdl_out = {m_ov, m_ctrl, m_a, m_b, m_rd};

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_reg[i]  = 16'h0000;
            m_pend[i] = 1'b0;
        end
        m_ov = 1'b0; m_ctrl = 2'b00; m_a = 16'h0000; m_b = 16'h0000; m_rd = 3'd0;
    endtask

    // Architectural value of a register as seen this cycle (writeback visible).
    function automatic logic [15:0] m_val(input logic [2:0] r);
        if (r == 3'd0) return 16'h0000;
        if (bus.wb_en && bus.wb_addr == r) return bus.wb_data;
        return m_reg[r];
    endfunction

    function automatic bit m_busy(input logic [2:0] r);
        return m_pend[r] && !(bus.wb_en && bus.wb_addr == r);
    endfunction

    task automatic drive(input logic iv, input logic [2:0] op,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                         input logic [7:0] imm, input logic wbe, input logic [2:0] wba,
                         input logic [15:0] wbd, input logic ordy);
        bus.in_valid  = iv;
        bus.in_op     = op;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.wb_en     = wbe;
        bus.wb_addr   = wba;
        bus.wb_data   = wbd;
        bus.out_ready = ordy;
    endtask

    // One clock: capture in_ready mid-cycle, advance the model, step past the edge.
    task automatic tick();
        bit hz;
        bit acc;
        @(negedge clk);
        obs_ready = bus.in_ready;
        hz = m_busy(bus.in_rs) || (!bus.in_op[2] && m_busy(bus.in_rt)) || m_busy(bus.in_rd);
        exp_ready = (!m_ov || bus.out_ready) && !hz;
        acc = bus.in_valid && exp_ready;
        if (acc) begin
            m_a    = m_val(bus.in_rs);
            m_b    = bus.in_op[2] ? {{8{bus.in_imm[7]}}, bus.in_imm} : m_val(bus.in_rt);
            m_ctrl = bus.in_op[1:0];
            m_rd   = bus.in_rd;
            m_ov   = 1'b1;
            $display("issue t=%0t op=%b rs=%0d rt=%0d rd=%0d imm=%h -> a=%h b=%h",
                     $time, bus.in_op, bus.in_rs, bus.in_rt, bus.in_rd, bus.in_imm, m_a, m_b);
        end else if (bus.out_ready) begin
            m_ov = 1'b0;
        end
        if (bus.wb_en) m_pend[bus.wb_addr] = 1'b0;
        if (acc && bus.in_rd != 3'd0) m_pend[bus.in_rd] = 1'b1;
        if (bus.wb_en && bus.wb_addr != 3'd0) m_reg[bus.wb_addr] = bus.wb_data;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Activity during reset must be ignored.
        drive(1, 3'b000, 3'd1, 3'd2, 3'd3, 8'h00, 1, 3'd2, 16'hBEEF, 1);
        #12;
        n_checks++;
        if (obs_out !== 38'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%h exp=%h", obs_out, 38'd0);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        drive(0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 1);
        reset = 1'b0;
        model_reset();
        $display("reset released t=%0t", $time);
    endtask

    task automatic test_sub_issue();
        drive(0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 1, 3'd1, 16'h0005, 1);
        tick();
        drive(0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 1, 3'd2, 16'h0003, 1);
        tick();
        drive(1, 3'b001, 3'd1, 3'd2, 3'd3, 8'h00, 0, 3'd0, 16'h0000, 1);
        tick();
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_in_ready got=%b exp=1", obs_ready);
        end
        n_checks++;
        if (obs_out !== {1'b1, 2'b01, 16'h0005, 16'h0003, 3'd3}) begin
            n_fail++;
            $display("FAIL sub_outputs got=%h exp=%h", obs_out, {1'b1, 2'b01, 16'h0005, 16'h0003, 3'd3});
        end
    endtask

    task automatic test_immediate();
        // rt=3 is pending but ignored because B comes from the immediate.
        drive(1, 3'b100, 3'd1, 3'd3, 3'd4, 8'hFE, 0, 3'd0, 16'h0000, 1);
        tick();
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL imm_in_ready got=%b exp=1", obs_ready);
        end
        n_checks++;
        if (obs_out !== {1'b1, 2'b00, 16'h0005, 16'hFFFE, 3'd4}) begin
            n_fail++;
            $display("FAIL imm_outputs got=%h exp=%h", obs_out, {1'b1, 2'b00, 16'h0005, 16'hFFFE, 3'd4});
        end
    endtask

    task automatic test_hazard_bypass();
        drive(1, 3'b000, 3'd3, 3'd0, 3'd5, 8'h00, 0, 3'd0, 16'h0000, 1);
        tick();
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_in_ready got=%b exp=0", obs_ready);
        end
        n_checks++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL hazard_drained got=%b exp=0", bus.out_valid);
        end
        drive(1, 3'b000, 3'd3, 3'd0, 3'd5, 8'h00, 1, 3'd3, 16'h1234, 1);
        tick();
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL bypass_in_ready got=%b exp=1", obs_ready);
        end
        n_checks++;
        if (obs_out !== {1'b1, 2'b00, 16'h1234, 16'h0000, 3'd5}) begin
            n_fail++;
            $display("FAIL bypass_outputs got=%h exp=%h", obs_out, {1'b1, 2'b00, 16'h1234, 16'h0000, 3'd5});
        end
    endtask

    task automatic test_back_to_back();
        drive(1, 3'b010, 3'd1, 3'd2, 3'd6, 8'h00, 0, 3'd0, 16'h0000, 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (obs_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_in_ready cycle=%0d got=%b exp=0", c, obs_ready);
            end
            n_checks++;
            if (obs_out !== {1'b1, 2'b00, 16'h1234, 16'h0000, 3'd5}) begin
                n_fail++;
                $display("FAIL stall_hold cycle=%0d got=%h exp=%h", c, obs_out, {1'b1, 2'b00, 16'h1234, 16'h0000, 3'd5});
            end
        end
        bus.out_ready = 1'b1;
        tick();
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL release_in_ready got=%b exp=1", obs_ready);
        end
        n_checks++;
        if (obs_out !== {1'b1, 2'b10, 16'h0005, 16'h0003, 3'd6}) begin
            n_fail++;
            $display("FAIL release_outputs got=%h exp=%h", obs_out, {1'b1, 2'b10, 16'h0005, 16'h0003, 3'd6});
        end
    endtask

    task automatic test_r0();
        drive(1, 3'b000, 3'd1, 3'd2, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 1);
        tick();
        n_checks++;
        if (obs_out !== {1'b1, 2'b00, 16'h0005, 16'h0003, 3'd0}) begin
            n_fail++;
            $display("FAIL rd0_outputs got=%h exp=%h", obs_out, {1'b1, 2'b00, 16'h0005, 16'h0003, 3'd0});
        end
        // rd=0 left nothing pending, and a write to r0 is not forwarded.
        drive(1, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 1, 3'd0, 16'hFFFF, 1);
        tick();
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rd0_in_ready got=%b exp=1", obs_ready);
        end
        n_checks++;
        if (obs_out !== {1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0}) begin
            n_fail++;
            $display("FAIL r0_bypass got=%h exp=%h", obs_out, {1'b1, 2'b00, 16'h0000, 16'h0000, 3'd0});
        end
        drive(1, 3'b011, 3'd0, 3'd1, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 1);
        tick();
        n_checks++;
        if (obs_out !== {1'b1, 2'b11, 16'h0000, 16'h0005, 3'd0}) begin
            n_fail++;
            $display("FAIL r0_read got=%h exp=%h", obs_out, {1'b1, 2'b11, 16'h0000, 16'h0005, 3'd0});
        end
    endtask

    task automatic test_reset_mid();
        // out_valid=1 from the previous issue; r5 still pending.
        drive(1, 3'b000, 3'd5, 3'd1, 3'd7, 8'h00, 0, 3'd0, 16'h0000, 0);
        tick();
        n_checks++;
        if (obs_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL premid_in_ready got=%b exp=0", obs_ready);
        end
        #2;
        drive(1, 3'b000, 3'd5, 3'd1, 3'd7, 8'h00, 1, 3'd1, 16'hAAAA, 0);
        reset = 1'b1;
        #1;
        n_checks++;
        if (obs_out !== 38'd0) begin
            n_fail++;
            $display("FAIL midreset_outputs got=%h exp=%h", obs_out, 38'd0);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_in_ready got=%b exp=1", bus.in_ready);
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_out !== 38'd0) begin
            n_fail++;
            $display("FAIL midreset_hold got=%h exp=%h", obs_out, 38'd0);
        end
        drive(0, 3'b000, 3'd0, 3'd0, 3'd0, 8'h00, 0, 3'd0, 16'h0000, 1);
        reset = 1'b0;
        model_reset();
        drive(1, 3'b000, 3'd5, 3'd1, 3'd5, 8'h00, 0, 3'd0, 16'h0000, 1);
        tick();
        n_checks++;
        if (obs_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL postreset_in_ready got=%b exp=1", obs_ready);
        end
        n_checks++;
        if (obs_out !== {1'b1, 2'b00, 16'h0000, 16'h0000, 3'd5}) begin
            n_fail++;
            $display("FAIL postreset_outputs got=%h exp=%h", obs_out, {1'b1, 2'b00, 16'h0000, 16'h0000, 3'd5});
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                  16'($urandom_range(0, 65535)), $urandom_range(0, 3) != 0);
            tick();
            n_checks++;
            if (obs_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL rand_in_ready cycle=%0d got=%b exp=%b", c, obs_ready, exp_ready);
            end
            n_checks++;
            if (obs_out !== mdl_out) begin
                n_fail++;
                $display("FAIL rand_outputs cycle=%0d got=%h exp=%h", c, obs_out, mdl_out);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_sub_issue();
        test_immediate();
        test_hazard_bypass();
        test_back_to_back();
        test_r0();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
